// File: rtl/ram_copy_pkg.sv
// rtl/ram_copy_pkg.sv - shared state encoding and default widths for the RAM copy engine
package ram_copy_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/ram_copy_addr_gen.sv
// rtl/ram_copy_addr_gen.sv - source/destination pointers and remaining word count for one copy
module ram_copy_addr_gen
    import ram_copy_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] src_in,
    input  logic [AW-1:0] dst_in,
    input  logic [AW-1:0] len_in,
    output logic [AW-1:0] src_ptr,
    output logic [AW-1:0] dst_ptr,
    output logic [AW-1:0] src_next,
    output logic          last
);

    logic [AW-1:0] remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
        end else if (load) begin
            src_ptr   <= src_in;
            dst_ptr   <= dst_in;
            remaining <= len_in;
        end else if (step) begin
            // pointers wrap naturally at 2**AW
            src_ptr   <= src_ptr + AW'(1);
            dst_ptr   <= dst_ptr + AW'(1);
            remaining <= remaining - AW'(1);
        end
    end

    assign src_next = src_ptr + AW'(1);
    assign last     = (remaining == AW'(1));

endmodule

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - single-port RAM copy engine, 3 cycles per word
// Optional running checksum of copied words enabled by RAM_COPY_CHECKSUM_EN.
module ram_copy_engine
    import ram_copy_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_wd,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
`ifdef RAM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    state_t        state;
    state_t        state_nx;
    logic          load;
    logic          step;
    logic          last;
    logic [AW-1:0] a_nx;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] src_next;

    ram_copy_addr_gen #(
        .AW(AW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .src_in  (src_addr),
        .dst_in  (dst_addr),
        .len_in  (len),
        .src_ptr (src_ptr),
        .dst_ptr (dst_ptr),
        .src_next(src_next),
        .last    (last)
    );

    // Outputs are registered from the next state, so the address for a
    // state is computed one edge ahead of entering it.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        a_nx     = ram_a;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RD;
                        a_nx     = src_addr;
                    end
                end
            end
            RD: begin
                state_nx = CAP;
            end
            CAP: begin
                state_nx = WR;
                a_nx     = dst_ptr;
            end
            WR: begin
                step = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end else begin
                    state_nx = RD;
                    a_nx     = src_next;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            ram_we <= 1'b0;
            ram_a  <= '0;
            ram_wd <= '0;
        end else begin
            state  <= state_nx;
            busy   <= (state_nx == RD) || (state_nx == CAP) || (state_nx == WR);
            done   <= (state_nx == DONE);
            ram_we <= (state_nx == WR);
            ram_a  <= a_nx;
            // ram_wd doubles as the data register written back in WR
            if (state == CAP) begin
                ram_wd <= ram_dout;
            end
        end
    end

`ifdef RAM_COPY_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || load) begin
            checksum <= '0;
        end else if (state == CAP) begin
            checksum <= checksum + ram_dout;
        end
    end
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - directed self-checking bench for ram_copy_engine with a dual-port RAM model
module tb_ram_copy_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] ram_a;
    logic [7:0] ram_wd;
    logic       ram_we;
    logic [7:0] ram_dout;
`ifdef RAM_COPY_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] mem [0:255];
    logic [7:0] a_q;
    logic       p0_we;
    logic [7:0] p0_a;
    logic [7:0] p0_wd;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_copy_engine dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .ram_a   (ram_a),
        .ram_wd  (ram_wd),
        .ram_we  (ram_we),
        .ram_dout(ram_dout)
`ifdef RAM_COPY_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    // Dual-port RAM: port 0 preloads from the bench, port 1 belongs to the DUT.
    always @(posedge clk) begin
        a_q <= ram_a;
        if (p0_we) mem[p0_a] <= p0_wd;
        if (ram_we) mem[ram_a] <= ram_wd;
    end
    assign ram_dout = mem[a_q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        p0_a  = a;
        p0_wd = d;
        p0_we = 1'b1;
        @(negedge clk);
        p0_we = 1'b0;
    endtask

    // Raises start for the cycle ending in edge 0 and returns just after edge 0.
    task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(posedge clk);
    endtask

    logic [7:0] rd2 [0:2];
    logic [7:0] wa2 [0:2];
    logic [7:0] wd2 [0:2];
    logic [7:0] rd4 [0:3];
    logic [7:0] wa4 [0:3];
    logic [7:0] wd4 [0:3];
    logic       done_seen;

    initial begin
        rd2 = '{8'h0A, 8'h0B, 8'h0C};
        wa2 = '{8'h28, 8'h29, 8'h2A};
        wd2 = '{8'hA1, 8'hB2, 8'hC3};
        rd4 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        wa4 = '{8'h20, 8'h21, 8'h22, 8'h23};
        wd4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        p0_we    = 1'b0;
        p0_a     = '0;
        p0_wd    = '0;

        // 1: reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ram_we", ram_we, 0);
        chk("rst ram_a", ram_a, 0);
        chk("rst ram_wd", ram_wd, 0);
`ifdef RAM_COPY_CHECKSUM_EN
        chk("rst checksum", checksum, 0);
`endif
        rst = 1'b0;

        poke(8'h0A, 8'hA1);
        poke(8'h0B, 8'hB2);
        poke(8'h0C, 8'hC3);
        poke(8'hFE, 8'h11);
        poke(8'hFF, 8'h22);
        poke(8'h00, 8'h33);
        poke(8'h01, 8'h44);

        // 2: three-word copy 10 -> 40
        issue(8'd10, 8'd40, 8'd3);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("t2 busy c%0d", c), busy, (c <= 9));
            chk($sformatf("t2 ram_we c%0d", c), ram_we, (c == 3 || c == 6 || c == 9));
            chk($sformatf("t2 done c%0d", c), done, (c == 10));
            if (c <= 9 && c % 3 == 1) chk($sformatf("t2 rd addr c%0d", c), ram_a, rd2[(c-1)/3]);
            if (c <= 9 && c % 3 == 0) begin
                chk($sformatf("t2 wr addr c%0d", c), ram_a, wa2[c/3-1]);
                chk($sformatf("t2 wr data c%0d", c), ram_wd, wd2[c/3-1]);
            end
`ifdef RAM_COPY_CHECKSUM_EN
            if (c >= 10) chk($sformatf("t2 checksum c%0d", c), checksum, 8'h16);
`endif
        end
        chk("t2 mem40", mem[40], 8'hA1);
        chk("t2 mem41", mem[41], 8'hB2);
        chk("t2 mem42", mem[42], 8'hC3);

        // 3: len = 0 is a no-op with an immediate done
        issue(8'd10, 8'd60, 8'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("t3 done c%0d", c), done, (c == 1));
            chk($sformatf("t3 busy c%0d", c), busy, 0);
            chk($sformatf("t3 ram_we c%0d", c), ram_we, 0);
        end

        // 4: source pointer wraps FF -> 00
        issue(8'hFE, 8'h20, 8'd4);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("t4 done c%0d", c), done, (c == 13));
            if (c <= 12 && c % 3 == 1) chk($sformatf("t4 rd addr c%0d", c), ram_a, rd4[(c-1)/3]);
            if (c <= 12 && c % 3 == 0) begin
                chk($sformatf("t4 wr addr c%0d", c), ram_a, wa4[c/3-1]);
                chk($sformatf("t4 wr data c%0d", c), ram_wd, wd4[c/3-1]);
                chk($sformatf("t4 ram_we c%0d", c), ram_we, 1);
            end
        end
        chk("t4 mem20", mem[8'h20], 8'h11);
        chk("t4 mem21", mem[8'h21], 8'h22);
        chk("t4 mem22", mem[8'h22], 8'h33);
        chk("t4 mem23", mem[8'h23], 8'h44);

        // 5: start during copy ignored, reset mid-copy aborts without done
        poke(8'd40, 8'h00);
        poke(8'd41, 8'h00);
        poke(8'd42, 8'h00);
        issue(8'd10, 8'd40, 8'd3);
        done_seen = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
            if (c == 5) begin
                chk("t5 busy c5", busy, 1);
                chk("t5 ram_we c5", ram_we, 0);
            end
            if (c == 6) begin
                chk("t5 busy c6", busy, 0);
                chk("t5 ram_we c6", ram_we, 0);
                chk("t5 ram_a c6", ram_a, 0);
                chk("t5 ram_wd c6", ram_wd, 0);
`ifdef RAM_COPY_CHECKSUM_EN
                chk("t5 checksum c6", checksum, 0);
`endif
            end
            if (c >= 7) chk($sformatf("t5 ram_we c%0d", c), ram_we, 0);
            start = (c == 4);
            rst   = (c == 5);
        end
        chk("t5 no done", done_seen, 0);
        chk("t5 mem40", mem[40], 8'hA1);
        chk("t5 mem41", mem[41], 8'h00);
        chk("t5 mem42", mem[42], 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
